// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver that recovers bytes from an asynchronous, idle-high serial line.
// Latency: the strobe lands 9.5 bit times + 3 cycles after the start-bit falling edge.
//   With UART_RX_PARITY_EN it lands 10.5 bit times + 3 cycles after that edge.
// Backpressure: none. o_RX_DV is a one-cycle strobe, and the host must take o_RX_Byte then or
//   later (it is held).
//
// Optional feature macro: UART_RX_PARITY_EN (adds an even-parity bit between data and stop).
//
// Ports:
//   i_Clock          system clock, rising edge
//   i_Reset          asynchronous active-high reset
//   i_RX_Serial      serial line (asynchronous, idle high)
//   o_RX_DV          one-cycle strobe: o_RX_Byte is valid and the frame is good
//   o_RX_Byte        last good byte, held until the next good frame
//   o_RX_Active      high from the accepted start bit until the receiver returns to idle
//   o_RX_Frame_Err   one-cycle strobe: stop bit sampled low
//   o_RX_Parity_Err  one-cycle strobe: parity mismatch (constant 0 without UART_RX_PARITY_EN)
`timescale 1ns/1ps

module uart_rx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_Active,
  output logic       o_RX_Frame_Err,
  output logic       o_RX_Parity_Err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_CLEANUP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_CLEANUP
  } state_t;
`endif

  // Two-flop synchroniser. It resets to the idle level so that leaving reset never looks
  // like a start bit.
  logic r_rx_meta;
  logic r_rx_s;

  state_t          r_state,   w_state_nxt;
  logic [CW-1:0]   r_clk_cnt, w_cnt_nxt;
  logic [2:0]      r_bit_idx, w_idx_nxt;
  logic [7:0]      r_data,    w_data_nxt;
  logic [7:0]      r_byte,    w_byte_nxt;
  logic            r_dv,      w_dv_nxt;
  logic            r_ferr,    w_ferr_nxt;
  logic            r_active,  w_active_nxt;
`ifdef UART_RX_PARITY_EN
  logic            r_par,     w_par_nxt;
  logic            r_perr,    w_perr_nxt;
  logic            w_par_bad;
`endif

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= i_RX_Serial;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= 3'd0;
      r_data    <= 8'h00;
      r_byte    <= 8'h00;
      r_dv      <= 1'b0;
      r_ferr    <= 1'b0;
      r_active  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par     <= 1'b0;
      r_perr    <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_clk_cnt <= w_cnt_nxt;
      r_bit_idx <= w_idx_nxt;
      r_data    <= w_data_nxt;
      r_byte    <= w_byte_nxt;
      r_dv      <= w_dv_nxt;
      r_ferr    <= w_ferr_nxt;
      r_active  <= w_active_nxt;
`ifdef UART_RX_PARITY_EN
      r_par     <= w_par_nxt;
      r_perr    <= w_perr_nxt;
`endif
    end
  end

`ifdef UART_RX_PARITY_EN
  // Even parity: the data bits and the parity bit must XOR to zero.
  assign w_par_bad = ^{r_data, r_par};
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_clk_cnt;
    w_idx_nxt    = r_bit_idx;
    w_data_nxt   = r_data;
    w_byte_nxt   = r_byte;
    w_active_nxt = r_active;
    // Strobes default low, so any strobe raised in STOP lasts exactly one cycle.
    w_dv_nxt     = 1'b0;
    w_ferr_nxt   = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_nxt    = r_par;
    w_perr_nxt   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_idx_nxt = 3'd0;
        if (!r_rx_s) w_state_nxt = S_START;
      end
      S_START: begin
        // Recheck the line at mid start bit. If it has gone high, treat it as a glitch.
        if (r_clk_cnt == HALF_CNT) begin
          w_cnt_nxt = '0;
          if (!r_rx_s) begin
            w_active_nxt = 1'b1;
            w_state_nxt  = S_DATA;
          end else begin
            w_state_nxt  = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_clk_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (r_clk_cnt < LAST_CNT) begin
          w_cnt_nxt = r_clk_cnt + 1'b1;
        end else begin
          w_cnt_nxt  = '0;
          // LSB arrives first. Shifting in from the top leaves it in bit 0 after eight bits.
          w_data_nxt = {r_rx_s, r_data[7:1]};
          if (r_bit_idx == 3'd7) begin
            w_idx_nxt   = 3'd0;
`ifdef UART_RX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (r_clk_cnt < LAST_CNT) begin
          w_cnt_nxt = r_clk_cnt + 1'b1;
        end else begin
          w_cnt_nxt   = '0;
          w_par_nxt   = r_rx_s;
          w_state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (r_clk_cnt < LAST_CNT) begin
          w_cnt_nxt = r_clk_cnt + 1'b1;
        end else begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_CLEANUP;
          // A framing error outranks a parity error. Only the first applicable strobe fires.
          if (!r_rx_s) begin
            w_ferr_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (w_par_bad) begin
            w_perr_nxt = 1'b1;
`endif
          end else begin
            w_byte_nxt = r_data;
            w_dv_nxt   = 1'b1;
          end
        end
      end
      S_CLEANUP: begin
        w_active_nxt = 1'b0;
        // Wait for the line to be high, so that a held-low break cannot start a phantom frame.
        if (r_rx_s) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign o_RX_DV        = r_dv;
  assign o_RX_Byte      = r_byte;
  assign o_RX_Active    = r_active;
  assign o_RX_Frame_Err = r_ferr;
`ifdef UART_RX_PARITY_EN
  assign o_RX_Parity_Err = r_perr;
`else
  assign o_RX_Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx. Serial frames are generated bit by bit from the byte values. A monitor logs
// every strobe, and each scenario task compares the logged results with expectations computed
// from the frame contents.
`timescale 1ns/1ps

module tb_uart_rx;
  localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  // 9.5 bit times (10.5 with parity) from the start edge, plus 3..4 cycles of pipeline.
  localparam int LAT_MIN = (CPB * 19) / 2 + (PAR_EN ? CPB : 0) + 3;
  localparam int LAT_MAX = LAT_MIN + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       dv;
  logic [7:0] rbyte;
  logic       act;
  logic       ferr;
  logic       perr;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock(clk),
    .i_Reset(rst),
    .i_RX_Serial(rx),
    .o_RX_DV(dv),
    .o_RX_Byte(rbyte),
    .o_RX_Active(act),
    .o_RX_Frame_Err(ferr),
    .o_RX_Parity_Err(perr)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] model_byte = 8'h00;   // last good byte the reference expects on o_RX_Byte

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: counts pulses (rising edges) and high cycles of each strobe, and logs the bytes.
  int dv_cnt = 0, dv_hi = 0, fe_cnt = 0, fe_hi = 0, pe_cnt = 0, pe_hi = 0;
  int act_cnt = 0, overlap = 0, last_dv_cyc = 0;
  logic prev_dv = 1'b0, prev_fe = 1'b0, prev_pe = 1'b0;
  logic [7:0] got_log[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (dv) begin
        dv_hi++;
        if (!prev_dv) begin
          dv_cnt++;
          got_log.push_back(rbyte);
          last_dv_cyc = cyc;
        end
      end
      if (ferr) begin
        fe_hi++;
        if (!prev_fe) fe_cnt++;
      end
      if (perr) begin
        pe_hi++;
        if (!prev_pe) pe_cnt++;
      end
      if ((dv && ferr) || (dv && perr) || (ferr && perr)) overlap++;
      if (act) act_cnt++;
    end
    prev_dv = dv;
    prev_fe = ferr;
    prev_pe = perr;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    tick(CPB);
  endtask

  // Leaves the line at the stop-bit level, so the caller decides what follows.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PAR_EN) drive_bit(par_b);
    drive_bit(stop_b);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx  = 1'b1;
    tick(4);
    checks++; if (dv !== 1'b0)      begin errors++; $display("FAIL reset_dv: got %b want 0", dv); end
    checks++; if (rbyte !== 8'h00)  begin errors++; $display("FAIL reset_byte: got %h want 00", rbyte); end
    checks++; if (act !== 1'b0)     begin errors++; $display("FAIL reset_active: got %b want 0", act); end
    checks++; if (ferr !== 1'b0)    begin errors++; $display("FAIL reset_ferr: got %b want 0", ferr); end
    checks++; if (perr !== 1'b0)    begin errors++; $display("FAIL reset_perr: got %b want 0", perr); end
    rst = 1'b0;
    tick(2 * CPB);
    checks++; if (act !== 1'b0)     begin errors++; $display("FAIL idle_active: got %b want 0", act); end
  endtask

  task automatic test_single;
    int b_dv, b_fe, b_pe, b_act, b_log, t0, lat;
    b_dv = dv_cnt; b_fe = fe_cnt; b_pe = pe_cnt; b_act = act_cnt; b_log = got_log.size();
    t0 = cyc;
    send_frame(8'hA5, 1'b1, ^8'hA5);
    rx = 1'b1;
    tick(2 * CPB);
    model_byte = 8'hA5;
    lat = last_dv_cyc - t0;
    checks++; if (dv_cnt - b_dv !== 1) begin errors++; $display("FAIL single_dv_count: got %0d want 1", dv_cnt - b_dv); end
    checks++; if (got_log.size() > b_log ? got_log[b_log] !== 8'hA5 : 1'b1)
      begin errors++; $display("FAIL single_byte: log size %0d, want A5 logged", got_log.size() - b_log); end
    checks++; if (fe_cnt - b_fe + pe_cnt - b_pe !== 0) begin errors++; $display("FAIL single_err: got %0d err strobes want 0", fe_cnt - b_fe + pe_cnt - b_pe); end
    checks++; if (rbyte !== model_byte) begin errors++; $display("FAIL single_hold: got %h want %h", rbyte, model_byte); end
    checks++; if (lat < LAT_MIN || lat > LAT_MAX) begin errors++; $display("FAIL single_latency: got %0d want %0d..%0d", lat, LAT_MIN, LAT_MAX); end
    checks++; if (act_cnt - b_act < 8 * CPB) begin errors++; $display("FAIL single_active_cycles: got %0d want >= %0d", act_cnt - b_act, 8 * CPB); end
    checks++; if (act !== 1'b0) begin errors++; $display("FAIL single_active_end: got %b want 0", act); end
  endtask

  task automatic test_back_to_back;
    int b_dv, b_log;
    b_dv = dv_cnt; b_log = got_log.size();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    rx = 1'b1;
    tick(2 * CPB);
    model_byte = 8'hFF;
    checks++; if (dv_cnt - b_dv !== 2) begin errors++; $display("FAIL b2b_dv_count: got %0d want 2", dv_cnt - b_dv); end
    checks++; if (got_log.size() > b_log ? got_log[b_log] !== 8'h00 : 1'b1)
      begin errors++; $display("FAIL b2b_first: missing or wrong, want 00"); end
    checks++; if (got_log.size() > b_log + 1 ? got_log[b_log + 1] !== 8'hFF : 1'b1)
      begin errors++; $display("FAIL b2b_second: missing or wrong, want FF"); end
  endtask

  task automatic test_glitch;
    int b_dv, b_fe, b_act;
    b_dv = dv_cnt; b_fe = fe_cnt; b_act = act_cnt;
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(3 * CPB);
    checks++; if (act_cnt - b_act !== 0) begin errors++; $display("FAIL glitch_active: got %0d active cycles want 0", act_cnt - b_act); end
    checks++; if (dv_cnt - b_dv + fe_cnt - b_fe !== 0) begin errors++; $display("FAIL glitch_strobe: got %0d strobes want 0", dv_cnt - b_dv + fe_cnt - b_fe); end
  endtask

  task automatic test_frame_err;
    int b_dv, b_fe, b_pe;
    b_dv = dv_cnt; b_fe = fe_cnt; b_pe = pe_cnt;
    send_frame(8'h3C, 1'b0, ^8'h3C);
    tick(40);                 // line stays low after the bad stop bit
    checks++; if (act !== 1'b0) begin errors++; $display("FAIL ferr_active_in_break: got %b want 0", act); end
    rx = 1'b1;
    tick(4 * CPB);
    checks++; if (fe_cnt - b_fe !== 1) begin errors++; $display("FAIL ferr_count: got %0d want 1", fe_cnt - b_fe); end
    checks++; if (dv_cnt - b_dv + pe_cnt - b_pe !== 0) begin errors++; $display("FAIL ferr_other: got %0d want 0", dv_cnt - b_dv + pe_cnt - b_pe); end
    checks++; if (rbyte !== model_byte) begin errors++; $display("FAIL ferr_hold: got %h want %h", rbyte, model_byte); end
    checks++; if (act !== 1'b0) begin errors++; $display("FAIL ferr_active_end: got %b want 0", act); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    int b_dv, b_fe, b_log;
    d = 8'h5A;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx = d[4];
    tick(CPB / 2);
    rst = 1'b1;
    tick(1);
    checks++; if (act !== 1'b0) begin errors++; $display("FAIL midrst_active: got %b want 0", act); end
    checks++; if (rbyte !== 8'h00) begin errors++; $display("FAIL midrst_byte: got %h want 00", rbyte); end
    rx = 1'b1;
    tick(3);
    rst = 1'b0;
    model_byte = 8'h00;
    tick(2 * CPB);
    b_dv = dv_cnt; b_fe = fe_cnt; b_log = got_log.size();
    send_frame(8'h81, 1'b1, ^8'h81);
    rx = 1'b1;
    tick(2 * CPB);
    model_byte = 8'h81;
    checks++; if (dv_cnt - b_dv !== 1) begin errors++; $display("FAIL midrst_dv_count: got %0d want 1", dv_cnt - b_dv); end
    checks++; if (got_log.size() > b_log ? got_log[b_log] !== 8'h81 : 1'b1)
      begin errors++; $display("FAIL midrst_byte_after: missing or wrong, want 81"); end
    checks++; if (fe_cnt - b_fe !== 0) begin errors++; $display("FAIL midrst_ferr: got %0d want 0", fe_cnt - b_fe); end
  endtask

  task automatic test_parity;
`ifdef UART_RX_PARITY_EN
    int b_dv, b_fe, b_pe, b_log;
    b_dv = dv_cnt; b_fe = fe_cnt; b_pe = pe_cnt; b_log = got_log.size();
    send_frame(8'h07, 1'b1, 1'b1);
    rx = 1'b1;
    tick(2 * CPB);
    model_byte = 8'h07;
    checks++; if (dv_cnt - b_dv !== 1) begin errors++; $display("FAIL par_good_dv: got %0d want 1", dv_cnt - b_dv); end
    checks++; if (got_log.size() > b_log ? got_log[b_log] !== 8'h07 : 1'b1)
      begin errors++; $display("FAIL par_good_byte: missing or wrong, want 07"); end
    b_dv = dv_cnt;
    send_frame(8'h07, 1'b1, 1'b0);
    rx = 1'b1;
    tick(2 * CPB);
    checks++; if (pe_cnt - b_pe !== 1) begin errors++; $display("FAIL par_bad_perr: got %0d want 1", pe_cnt - b_pe); end
    checks++; if (dv_cnt - b_dv !== 0) begin errors++; $display("FAIL par_bad_dv: got %0d want 0", dv_cnt - b_dv); end
    checks++; if (rbyte !== model_byte) begin errors++; $display("FAIL par_bad_hold: got %h want %h", rbyte, model_byte); end
    b_pe = pe_cnt;
    send_frame(8'h07, 1'b0, 1'b0);
    rx = 1'b1;
    tick(3 * CPB);
    checks++; if (fe_cnt - b_fe !== 1 || pe_cnt - b_pe !== 0)
      begin errors++; $display("FAIL par_both_prec: got ferr %0d perr %0d want 1 0", fe_cnt - b_fe, pe_cnt - b_pe); end
`else
    checks++; if (pe_cnt !== 0 || perr !== 1'b0) begin errors++; $display("FAIL noparity_perr: got %0d pulses want 0", pe_cnt); end
`endif
  endtask

  task automatic test_random;
    logic [7:0] exp_q[$];
    logic [7:0] d;
    logic       stop_b, par_bad;
    int exp_fe, exp_pe, gap, b_dv, b_fe, b_pe, b_log;
    exp_fe = 0; exp_pe = 0;
    b_dv = dv_cnt; b_fe = fe_cnt; b_pe = pe_cnt; b_log = got_log.size();
    for (int n = 0; n < 12; n++) begin
      d       = 8'($urandom);
      stop_b  = ($urandom % 4) != 0;
      par_bad = PAR_EN && (($urandom % 4) == 0);
      send_frame(d, stop_b, (^d) ^ par_bad);
      if (!stop_b) begin
        exp_fe++;
        gap = 2 * CPB + int'($urandom % CPB);
      end else begin
        if (par_bad) exp_pe++;
        else begin
          exp_q.push_back(d);
          model_byte = d;
        end
        gap = int'($urandom % (2 * CPB));
      end
      rx = 1'b1;
      tick(gap);
    end
    tick(3 * CPB);
    checks++; if (dv_cnt - b_dv !== exp_q.size()) begin errors++; $display("FAIL rand_dv_count: got %0d want %0d", dv_cnt - b_dv, exp_q.size()); end
    checks++; if (fe_cnt - b_fe !== exp_fe) begin errors++; $display("FAIL rand_ferr_count: got %0d want %0d", fe_cnt - b_fe, exp_fe); end
    checks++; if (pe_cnt - b_pe !== exp_pe) begin errors++; $display("FAIL rand_perr_count: got %0d want %0d", pe_cnt - b_pe, exp_pe); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (b_log + i >= got_log.size()) begin
        errors++; $display("FAIL rand_byte[%0d]: missing want %h", i, exp_q[i]);
      end else if (got_log[b_log + i] !== exp_q[i]) begin
        errors++; $display("FAIL rand_byte[%0d]: got %h want %h", i, got_log[b_log + i], exp_q[i]);
      end
    end
    checks++; if (rbyte !== model_byte) begin errors++; $display("FAIL rand_hold: got %h want %h", rbyte, model_byte); end
  endtask

  task automatic test_strobe_shape;
    checks++; if (dv_hi !== dv_cnt) begin errors++; $display("FAIL dv_width: got %0d high cycles want %0d", dv_hi, dv_cnt); end
    checks++; if (fe_hi !== fe_cnt) begin errors++; $display("FAIL ferr_width: got %0d high cycles want %0d", fe_hi, fe_cnt); end
    checks++; if (pe_hi !== pe_cnt) begin errors++; $display("FAIL perr_width: got %0d high cycles want %0d", pe_hi, pe_cnt); end
    checks++; if (overlap !== 0) begin errors++; $display("FAIL strobe_overlap: got %0d want 0", overlap); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    tick(1);
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_parity();
    test_random();
    test_strobe_shape();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
